pipelined_addsub: RTL
=====================

Name: pipelined_addsub

Overview:
- Parametrised, pipelined add/subtract unit; next generation of the team's fixed-width ripple-carry adder.
- Splits a WIDTH-bit operation into STAGES chunk slices, registering the inter-chunk carry at each stage.
- Adds valid/ready flow control, a subtract mode and carry/overflow flags.
- Sits between operand-producing datapath blocks and result consumers in the ALU/DSP datapaths.

Parameters:
- WIDTH, 32, operand and result width in bits; must be at least 2.
- STAGES, 4, number of pipeline stages, which is also the latency in cycles; WIDTH % STAGES must be 0 and STAGES >= 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  unit accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result.
- s  output  WIDTH  sum or difference.
- cout  output  1  carry-out; in subtract mode 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (asserts async, deasserts sync to clk): all stage valid bits = 0, out_valid = 0, s = 0, cout = 0, ovf = 0. in_ready = 1 once reset is released.
- Reset mid-operation: all in-flight beats are discarded; nothing is emitted after release.
- Operand transform:
  - b_eff = b XOR {WIDTH{sub}}, c_eff = cin XOR sub.
  - sub=1, cin=0 computes a-b; sub=1, cin=1 computes a-b-1.
- Chunking: CH = WIDTH/STAGES. Stage k adds bits [k*CH +: CH] of a and b_eff with the carry registered out of stage k-1 (stage 0 uses c_eff).
- Skew and deskew:
  - Upper operand chunks travel in skew registers alongside the pipeline.
  - Lower result chunks are carried forward so that s is complete at the output register.
- Flags:
  - cout = final-stage carry-out.
  - ovf = (a[MSB] == b_eff[MSB]) && (s[MSB] != a[MSB]), evaluated in the final stage.
- Flow control uses a global stall:
  - adv = !out_valid || out_ready.
  - in_ready = adv.
  - When adv = 1, every stage register (valid included) shifts forward one stage.
  - When adv = 0, all stage registers hold.
  - Accepted beat = in_valid && in_ready. A stage's valid bit is loaded with in_valid at stage 0.
- Latency and throughput:
  - Exactly STAGES cycles from acceptance to out_valid when there is no backpressure.
  - Throughput is one beat per cycle.
- Bubbles propagate as invalid slots; the unit does not collapse bubbles.
- Output hold: while out_valid && !out_ready, s, cout and ovf hold stable.
- Wrap-around: results are modulo 2^WIDTH. Example: 0xFFFFFFFF + 1 gives s = 0, cout = 1.
- STAGES = 1: a single registered full-width add with latency 1.
- Simultaneous accept and emit in the same cycle is legal and required for full throughput.

Optional Feature:
- Macro: PIPELINED_ADDSUB_SAT_EN.
- Defined:
  - Adds input port sat (1 bit), sampled with the operands and pipelined alongside them.
  - When sat = 1 and ovf = 1 at the final stage, s clamps to signed max (0x7FFF_FFFF for WIDTH=32) if a[MSB] = 0, else to signed min (0x8000_0000).
  - ovf and cout still report the unsaturated result.
- Undefined: no sat port and no clamp logic; s is always the modulo result.

Decomposition:
- Package addsub_pkg:
  - Function chunk_w(WIDTH, STAGES).
  - Functions sat_max(WIDTH) and sat_min(WIDTH).
  - Typedef of the stage-register struct: valid, carry, partial sum, skewed a/b_eff, sat.
  - An elaboration check that WIDTH % STAGES == 0.
- One sub-module, addsub_chunk: a combinational CH-bit ripple adder with carry-in and carry-out, instantiated once per stage from a generate loop.

Test Plan:
- Reset then WIDTH=32, STAGES=4, add 0x0000_0001 + 0x0000_0002, cin=0 -> out_valid exactly 4 cycles after accept; s = 0x0000_0003, cout = 0, ovf = 0.
- Add 0xFFFF_FFFF + 0x0000_0000, cin=1 -> s = 0, cout = 1 (carry ripples across every chunk boundary); add 0x7FFF_FFFF + 1 -> s = 0x8000_0000, ovf = 1.
- sub=1: 5 - 7 -> s = 0xFFFF_FFFE, cout = 0; 7 - 5 -> s = 2, cout = 1; sub=1, cin=1 on 7 - 5 -> s = 1.
- Stream 16 back-to-back beats while out_ready toggles in the pattern 1,0,0,1,... -> no beat lost or duplicated; results in order; outputs stable while stalled; in_ready == !out_valid || out_ready.
- Assert rst_n low with 3 beats in flight -> out_valid = 0 immediately (async); no stale result after release.
- PIPELINED_ADDSUB_SAT_EN, sat=1: 0x7FFF_FFFF + 1 -> s = 0x7FFF_FFFF, ovf = 1; 0x8000_0000 - 1 -> s = 0x8000_0000. Repeat directed cases at STAGES=1 and WIDTH=8, STAGES=2.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared helpers and types for the pipelined add/subtract unit.
// The stage control struct carries a sat bit only when PIPELINED_ADDSUB_SAT_EN is defined.
package addsub_pkg;

  localparam int ADDSUB_MAX_W = 64;

  typedef struct packed {
    logic valid;
    logic carry;
`ifdef PIPELINED_ADDSUB_SAT_EN
    logic sat;
`endif
  } stage_ctl_t;

  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic logic [ADDSUB_MAX_W-1:0] sat_max(input int width);
    return (ADDSUB_MAX_W'(1) << (width - 1)) - ADDSUB_MAX_W'(1);
  endfunction

  function automatic logic [ADDSUB_MAX_W-1:0] sat_min(input int width);
    return ADDSUB_MAX_W'(1) << (width - 1);
  endfunction

  function automatic bit geometry_ok(input int width, input int stages);
    return (stages >= 1) && (width >= 2) && (width <= ADDSUB_MAX_W) &&
           ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CH-bit ripple-carry adder slice used by every pipeline stage.
module addsub_chunk #(
  parameter int CH = 8
) (
  input  logic [CH-1:0] a,
  input  logic [CH-1:0] b,
  input  logic          cin,
  output logic [CH-1:0] sum,
  output logic          cout
);

  logic c;

  always_comb begin
    sum = '0;
    c   = cin;
    for (int i = 0; i < CH; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit: one CH-bit chunk per stage, global-stall valid/ready.
// Optional saturation enabled by defining PIPELINED_ADDSUB_SAT_EN.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
`ifdef PIPELINED_ADDSUB_SAT_EN
  ,
  input  logic             sat
`endif
);

  localparam int CH = chunk_w(WIDTH, STAGES);

  if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
    $error("pipelined_addsub: WIDTH must be >= 2 and a multiple of STAGES");
  end

  stage_ctl_t       ctl_q [STAGES];
  stage_ctl_t       ctl_d [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] ps_q  [STAGES];
  logic [WIDTH-1:0] ps_d  [STAGES];
  logic             ovf_q;
  logic             ovf_d;
  logic             adv;

  assign adv       = !ctl_q[STAGES-1].valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = ctl_q[STAGES-1].valid;
  assign s         = ps_q[STAGES-1];
  assign cout      = ctl_q[STAGES-1].carry;
  assign ovf       = ovf_q;

  // Operands shift right one chunk per stage; result chunks enter at the top and
  // shift down, so the full sum is aligned once the last chunk lands.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [WIDTH-1:0] ps_i;
    stage_ctl_t       ctl_i;
    logic [CH-1:0]    sum;
    logic             co;
    logic [WIDTH-1:0] ps_raw;

    if (k == 0) begin : g_head
      assign a_i         = a;
      assign b_i         = b ^ {WIDTH{sub}};
      assign ps_i        = '0;
      assign ctl_i.valid = in_valid;
      assign ctl_i.carry = cin ^ sub;
`ifdef PIPELINED_ADDSUB_SAT_EN
      assign ctl_i.sat   = sat;
`endif
    end else begin : g_body
      assign a_i   = a_q[k-1];
      assign b_i   = b_q[k-1];
      assign ps_i  = ps_q[k-1];
      assign ctl_i = ctl_q[k-1];
    end

    addsub_chunk #(.CH(CH)) u_chunk (
      .a    (a_i[CH-1:0]),
      .b    (b_i[CH-1:0]),
      .cin  (ctl_i.carry),
      .sum  (sum),
      .cout (co)
    );

    assign ps_raw          = (ps_i >> CH) | (WIDTH'(sum) << (WIDTH - CH));
    assign a_d[k]          = a_i >> CH;
    assign b_d[k]          = b_i >> CH;
    assign ctl_d[k].valid  = ctl_i.valid;
    assign ctl_d[k].carry  = co;
`ifdef PIPELINED_ADDSUB_SAT_EN
    assign ctl_d[k].sat    = ctl_i.sat;
`endif

    if (k == STAGES - 1) begin : g_tail
      assign ovf_d = (a_i[CH-1] == b_i[CH-1]) && (sum[CH-1] != a_i[CH-1]);
`ifdef PIPELINED_ADDSUB_SAT_EN
      assign ps_d[k] = (ctl_i.sat && ovf_d) ?
                       (a_i[CH-1] ? WIDTH'(sat_min(WIDTH)) : WIDTH'(sat_max(WIDTH))) :
                       ps_raw;
`else
      assign ps_d[k] = ps_raw;
`endif
    end else begin : g_mid
      assign ps_d[k] = ps_raw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        ctl_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        ps_q[k]  <= '0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        ctl_q[k] <= ctl_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        ps_q[k]  <= ps_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

endmodule
